// File: rtl/sprite_fb_writer.sv
// sprite_fb_writer: frame-buffer write side of the sprite pipeline.
// Pixel stream -> screen address -> FIFO -> 3-phase SRAM write.
module sprite_fb_writer #(
   parameter int SCREEN_W    = 320,
   parameter int SCREEN_H    = 240,
   parameter int ADDR_W      = 17,
   parameter int COLOR_W     = 4,
   parameter int TRANSPARENT = 0,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               start,
   input  logic [8:0]         org_x,
   input  logic [7:0]         org_y,
   input  logic               pix_valid,
   input  logic [3:0]         pix_x,
   input  logic [3:0]         pix_y,
   input  logic [COLOR_W-1:0] pix_color,
   input  logic               pix_last,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_wdata,
   output logic               fb_ce_n,
   output logic               fb_we_n,
   output logic               busy,
   output logic               done,
   output logic               overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = ADDR_W + COLOR_W + 2;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_STROBE = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   localparam logic [9:0] SW_LIM = 10'(SCREEN_W);
   localparam logic [8:0] SH_LIM = 9'(SCREEN_H);
   localparam logic [COLOR_W-1:0] TRANSP = COLOR_W'(TRANSPARENT);

   // control / origin
   logic               busy_q, busy_d;
   logic [8:0]         org_x_q, org_x_d;
   logic [7:0]         org_y_q, org_y_d;
   logic               done_q, done_d;
   logic               overflow_q, overflow_d;

   // stage 1
   logic               s1_valid_q, s1_valid_d;
   logic [9:0]         s1_sx_q, s1_sx_d;
   logic [8:0]         s1_sy_q, s1_sy_d;
   logic [COLOR_W-1:0] s1_color_q, s1_color_d;
   logic               s1_last_q, s1_last_d;

   // FIFO
   logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
   logic               empty, full, push, drop, pop;

   // stage 2 entry
   logic [ADDR_W-1:0]  ent_addr;
   logic               ent_skip;
   logic [ENT_W-1:0]   ent;

   // FIFO head fields
   logic [ENT_W-1:0]   head;
   logic [ADDR_W-1:0]  head_addr;
   logic [COLOR_W-1:0] head_color;
   logic               head_last;
   logic               head_skip;

   // write FSM
   logic [1:0]         state_q, state_d;
   logic               cur_last_q, cur_last_d;
   logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
   logic [COLOR_W-1:0] fb_wdata_q, fb_wdata_d;
   logic               retire_last;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign head_addr  = head[ENT_W-1 -: ADDR_W];
   assign head_color = head[COLOR_W+1:2];
   assign head_last  = head[1];
   assign head_skip  = head[0];

   // start / busy / done / overflow bookkeeping
   always_comb begin
      busy_d     = busy_q;
      org_x_d    = org_x_q;
      org_y_d    = org_y_q;
      overflow_d = overflow_q;
      done_d     = retire_last;
      if (start && !busy_q) begin
         busy_d     = 1'b1;
         org_x_d    = org_x;
         org_y_d    = org_y;
         overflow_d = 1'b0;
      end else if (retire_last) begin
         busy_d = 1'b0;
      end
      if (drop)
         overflow_d = 1'b1;
   end

   // stage 1: origin-relative to screen coordinates
   always_comb begin
      s1_valid_d = pix_valid && busy_q;
      s1_sx_d    = s1_sx_q;
      s1_sy_d    = s1_sy_q;
      s1_color_d = s1_color_q;
      s1_last_d  = s1_last_q;
      if (pix_valid && busy_q) begin
         s1_sx_d    = 10'(org_x_q) + 10'(pix_x);
         s1_sy_d    = 9'(org_y_q) + 9'(pix_y);
         s1_color_d = pix_color;
         s1_last_d  = pix_last;
      end
   end

   // stage 2: linear address and skip flag for the FIFO entry
   always_comb begin
      ent_addr = ADDR_W'(32'(s1_sy_q) * 32'(SCREEN_W)
                         + 32'(s1_sx_q));
      ent_skip = (s1_color_q == TRANSP) ||
                 (s1_sx_q >= SW_LIM) ||
                 (s1_sy_q >= SH_LIM);
      ent      = {ent_addr, s1_color_q, s1_last_q, ent_skip};
   end

   // FIFO push/pop; a pop this cycle frees room for a push
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      push     = s1_valid_q && (!full || pop);
      drop     = s1_valid_q && full && !pop;
      if (push) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = ent;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // write FSM: pop in IDLE/HOLD, then SETUP -> STROBE -> HOLD
   always_comb begin
      state_d     = state_q;
      cur_last_d  = cur_last_q;
      fb_addr_d   = fb_addr_q;
      fb_wdata_d  = fb_wdata_q;
      pop         = 1'b0;
      retire_last = 1'b0;
      case (state_q)
         ST_SETUP:  state_d = ST_STROBE;
         ST_STROBE: state_d = ST_HOLD;
         default: begin
            if (state_q == ST_HOLD && cur_last_q)
               retire_last = 1'b1;
            cur_last_d = 1'b0;
            state_d    = ST_IDLE;
            if (!empty) begin
               pop = 1'b1;
               if (head_skip) begin
                  if (head_last)
                     retire_last = 1'b1;
               end else begin
                  state_d    = ST_SETUP;
                  cur_last_d = head_last;
                  fb_addr_d  = head_addr;
                  fb_wdata_d = head_color;
               end
            end
         end
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         busy_q     <= 1'b0;
         org_x_q    <= '0;
         org_y_q    <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_sx_q    <= '0;
         s1_sy_q    <= '0;
         s1_color_q <= '0;
         s1_last_q  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         state_q    <= ST_IDLE;
         cur_last_q <= 1'b0;
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
      end else begin
         busy_q     <= busy_d;
         org_x_q    <= org_x_d;
         org_y_q    <= org_y_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         s1_valid_q <= s1_valid_d;
         s1_sx_q    <= s1_sx_d;
         s1_sy_q    <= s1_sy_d;
         s1_color_q <= s1_color_d;
         s1_last_q  <= s1_last_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         state_q    <= state_d;
         cur_last_q <= cur_last_d;
         fb_addr_q  <= fb_addr_d;
         fb_wdata_q <= fb_wdata_d;
      end
   end

   assign fb_addr  = fb_addr_q;
   assign fb_wdata = fb_wdata_q;
   assign fb_ce_n  = (state_q == ST_IDLE);
   assign fb_we_n  = (state_q != ST_STROBE);
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_sprite_fb_writer.sv
// tb_sprite_fb_writer: directed stimulus with a write scoreboard.
// Expected SRAM writes are queued; a negedge monitor checks them.
module tb_sprite_fb_writer;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  org_x = '0;
   logic [7:0]  org_y = '0;
   logic        pix_valid = 1'b0;
   logic [3:0]  pix_x = '0;
   logic [3:0]  pix_y = '0;
   logic [3:0]  pix_color = '0;
   logic        pix_last = 1'b0;
   logic [16:0] fb_addr;
   logic [3:0]  fb_wdata;
   logic        fb_ce_n, fb_we_n, busy, done, overflow;

   sprite_fb_writer dut (
      .Clk(Clk), .Reset(Reset), .start(start),
      .org_x(org_x), .org_y(org_y),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_color(pix_color), .pix_last(pix_last),
      .fb_addr(fb_addr), .fb_wdata(fb_wdata),
      .fb_ce_n(fb_ce_n), .fb_we_n(fb_we_n),
      .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_wr = 0;
   int n_done = 0;
   bit sb_en = 1'b0;
   logic [16:0] exp_a[$];
   logic [3:0]  exp_d[$];
   logic [16:0] prev_addr = '0;
   logic        prev_ce_n = 1'b1;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_start(input int x, input int y);
      start = 1'b1;
      org_x = 9'(x);
      org_y = 8'(y);
      tick();
      start = 1'b0;
   endtask

   task automatic pix(input int x, input int y,
                      input int c, input bit last);
      pix_valid = 1'b1;
      pix_x     = 4'(x);
      pix_y     = 4'(y);
      pix_color = 4'(c);
      pix_last  = last;
      tick();
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic expect_wr(input int a, input int d);
      exp_a.push_back(17'(a));
      exp_d.push_back(4'(d));
   endtask

   task automatic wait_done(input int budget, input string name);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      check(name, 32'(done), 32'd1);
   endtask

   // monitor: every strobe is checked against the scoreboard
   always @(negedge Clk) begin
      logic [16:0] a;
      logic [3:0]  d;
      if (fb_we_n === 1'b0) begin
         n_wr++;
         check("we_implies_ce", 32'(fb_ce_n), 32'd0);
         if (prev_ce_n === 1'b0)
            check("addr_stable", 32'(fb_addr), 32'(prev_addr));
         if (sb_en) begin
            if (exp_a.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: addr %0d data %0d",
                        fb_addr, fb_wdata);
            end else begin
               a = exp_a.pop_front();
               d = exp_d.pop_front();
               check("wr_addr", 32'(fb_addr), 32'(a));
               check("wr_data", 32'(fb_wdata), 32'(d));
            end
         end
      end
      if (done === 1'b1)
         n_done++;
      prev_addr <= fb_addr;
      prev_ce_n <= fb_ce_n;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      int w0;
      int d0;

      // reset state
      Reset = 1'b1;
      tick();
      tick();
      check("rst_ce_n", 32'(fb_ce_n), 32'd1);
      check("rst_we_n", 32'(fb_we_n), 32'd1);
      check("rst_addr", 32'(fb_addr), 32'd0);
      check("rst_wdata", 32'(fb_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      Reset = 1'b0;
      tick();

      // pixels while not busy are ignored
      w0 = n_wr;
      pix(1, 1, 5, 1'b0);
      pix(2, 2, 5, 1'b1);
      repeat (8) tick();
      check("idle_no_write", 32'(n_wr - w0), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ce_n", 32'(fb_ce_n), 32'd1);
      sb_en = 1'b1;

      // single pixel timing: 20*320+10 = 6410
      do_start(10, 20);
      check("sp_busy", 32'(busy), 32'd1);
      expect_wr(6410, 5);
      pix(0, 0, 5, 1'b1);
      tick();
      tick();
      check("sp_setup_we", 32'(fb_we_n), 32'd1);
      check("sp_setup_ce", 32'(fb_ce_n), 32'd0);
      tick();
      check("sp_strobe_we", 32'(fb_we_n), 32'd0);
      check("sp_strobe_addr", 32'(fb_addr), 32'd6410);
      check("sp_strobe_data", 32'(fb_wdata), 32'd5);
      tick();
      check("sp_hold_we", 32'(fb_we_n), 32'd1);
      check("sp_hold_ce", 32'(fb_ce_n), 32'd0);
      tick();
      check("sp_done", 32'(done), 32'd1);
      check("sp_busy_low", 32'(busy), 32'd0);
      tick();
      check("sp_done_pulse", 32'(done), 32'd0);
      check("sp_idle_ce", 32'(fb_ce_n), 32'd1);

      // full 15x15 sprite, one pixel every 3 cycles
      w0 = n_wr;
      d0 = n_done;
      do_start(10, 20);
      for (int y = 0; y < 15; y++) begin
         for (int x = 0; x < 15; x++) begin
            expect_wr((20 + y) * 320 + 10 + x, 3);
            pix(x, y, 3, (x == 14 && y == 14));
            tick();
            tick();
         end
      end
      wait_done(40, "fs_done");
      check("fs_last_addr", 32'(fb_addr), 32'd10904);
      repeat (3) tick();
      check("fs_writes", 32'(n_wr - w0), 32'd225);
      check("fs_done_cnt", 32'(n_done - d0), 32'd1);
      check("fs_ovf", 32'(overflow), 32'd0);
      check("fs_busy", 32'(busy), 32'd0);

      // clipping and transparency
      w0 = n_wr;
      d0 = n_done;
      do_start(315, 0);
      expect_wr(319, 7);
      pix(4, 0, 7, 1'b0);
      tick();
      tick();
      pix(5, 0, 7, 1'b0);
      tick();
      tick();
      pix(0, 1, 0, 1'b1);
      wait_done(40, "sk_done");
      repeat (3) tick();
      check("sk_writes", 32'(n_wr - w0), 32'd1);
      check("sk_addr", 32'(fb_addr), 32'd319);
      check("sk_done_cnt", 32'(n_done - d0), 32'd1);

      // overflow: eight back-to-back pixels
      sb_en = 1'b0;
      w0 = n_wr;
      do_start(20, 20);
      for (int i = 0; i < 8; i++)
         pix(i, 0, i + 1, (i == 7));
      wait_done(80, "ov_done");
      repeat (2) tick();
      check("ov_flag", 32'(overflow), 32'd1);
      check("ov_fewer", 32'(n_wr - w0 < 8), 32'd1);
      check("ov_some", 32'(n_wr - w0 > 0), 32'd1);
      sb_en = 1'b1;
      do_start(0, 0);
      check("ov_cleared", 32'(overflow), 32'd0);
      pix(0, 0, 0, 1'b1);
      wait_done(20, "ov_close_done");
      tick();

      // reset during STROBE: 1*320+1 = 321
      do_start(0, 0);
      expect_wr(321, 9);
      pix(1, 1, 9, 1'b1);
      tick();
      tick();
      tick();
      check("rm_strobe", 32'(fb_we_n), 32'd0);
      Reset = 1'b1;
      tick();
      check("rm_we_n", 32'(fb_we_n), 32'd1);
      check("rm_ce_n", 32'(fb_ce_n), 32'd1);
      check("rm_busy", 32'(busy), 32'd0);
      check("rm_addr", 32'(fb_addr), 32'd0);
      check("rm_done", 32'(done), 32'd0);
      Reset = 1'b0;
      w0 = n_wr;
      d0 = n_done;
      repeat (10) tick();
      check("rm_no_write", 32'(n_wr - w0), 32'd0);
      check("rm_no_done", 32'(n_done - d0), 32'd0);

      // normal write after reset: 2*320+4 = 644
      do_start(1, 2);
      expect_wr(644, 12);
      pix(3, 0, 12, 1'b1);
      wait_done(20, "rr_done");
      check("rr_addr", 32'(fb_addr), 32'd644);
      repeat (3) tick();
      check("sb_drained", 32'(exp_a.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sprite_fb_writer.md
# sprite_fb_writer

Frame-buffer write side of the sprite pipeline. Consumes the per-pixel stream from the sprite memory reader: a pixel strobe plus in-sprite x/y (0–14) and palette index. It translates each pixel to a screen address from a latched sprite origin, drops transparent and off-screen pixels, and buffers pixels in a small FIFO. It then performs 3-phase writes (setup/strobe/hold) to the frame-buffer SRAM. It signals completion once the pixel tagged last has retired.

## Interface
- SCREEN_W, 320, screen width in pixels
- SCREEN_H, 240, screen height in pixels
- ADDR_W, 17, frame-buffer address width
- COLOR_W, 4, palette index width
- TRANSPARENT, 0, palette index that is never written
- FIFO_DEPTH, 4, pixel FIFO entries (power of 2)
- Clk  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; latches org_x/org_y; ignored while busy
- org_x  in  9  sprite origin x (screen pixels)
- org_y  in  8  sprite origin y
- pix_valid  in  1  pixel strobe; ignored while busy=0
- pix_x  in  4  in-sprite column 0–14
- pix_y  in  4  in-sprite row 0–14
- pix_color  in  COLOR_W  palette index
- pix_last  in  1  qualifies the final pixel of the sprite
- fb_addr  out  ADDR_W  SRAM address
- fb_wdata  out  COLOR_W  SRAM write data
- fb_ce_n  out  1  SRAM chip enable, active-low
- fb_we_n  out  1  SRAM write enable, active-low
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full; cleared by start or Reset

## Operation
- Stage 1, registered on pix_valid && busy:
  - sx = org_x + pix_x, 10 bits.
  - sy = org_y + pix_y, 9 bits.
  - color and last are carried with the pixel.
- Stage 2, push to FIFO:
  - Entry = {addr = sy*SCREEN_W + sx truncated to ADDR_W, color, last, skip}.
  - skip = (color == TRANSPARENT) || (sx >= SCREEN_W) || (sy >= SCREEN_H).
  - Skipped pixels are still pushed so that last is never lost.
- If the FIFO is full at push, the entry is discarded and overflow is set. If that entry carried last, done is never produced; recovery is Reset only.
- Write FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE or HOLD with FIFO non-empty: pop into the current-entry register. Go to SETUP if not skip, otherwise to IDLE. IDLE or HOLD with FIFO empty: go to IDLE.
  - SETUP: fb_ce_n=0, fb_we_n=1, fb_addr/fb_wdata = entry. Next state STROBE.
  - STROBE: fb_ce_n=0, fb_we_n=0, addr/data held. Next state HOLD.
  - HOLD: fb_ce_n=0, fb_we_n=1, addr/data held. Pops per the rule above.
  - IDLE: fb_ce_n=1, fb_we_n=1. fb_addr/fb_wdata keep their last value.
- Retirement:
  - A write entry retires at the end of HOLD.
  - A skip entry retires in the cycle it is popped.
  - When a last entry retires, done=1 and busy=0 in the following cycle.
- start while busy is ignored. start together with pix_valid while idle: the pixel is ignored.

## Timing
- start sampled in cycle s → busy=1 from s+1. The origin is used for pixels sampled from s+1 on.
- pix_valid sampled in cycle n → stage1 valid in n+1 → FIFO entry visible in n+2 → popped in n+2 if the FSM is IDLE → SETUP n+3, STROBE n+4 (fb_we_n low for exactly this cycle), HOLD n+5.
- For a last opaque pixel with an empty pipe, done is asserted in n+6.
- Sustained throughput is one write per 3 cycles (HOLD→SETUP back-to-back). This matches the reader rate of one pixel per 3 cycles, so there is no overflow at that rate.
- Skip entries cost 1 cycle each.
- fb_we_n is never low unless fb_ce_n is low, and addr/data are stable in SETUP, STROBE and HOLD.
- Reset at any point takes effect at the next edge:
  - FSM→IDLE, FIFO and stage1 emptied.
  - fb_ce_n=1, fb_we_n=1, fb_addr=0, fb_wdata=0, busy=0, done=0, overflow=0.
  - A strobe in progress is truncated (fb_we_n=1 the next cycle).

## Test plan
- Reset: hold Reset 2 cycles → fb_ce_n=1, fb_we_n=1, fb_addr=0, fb_wdata=0, busy=0, done=0, overflow=0. Then pix_valid with busy=0 → no SRAM activity.
- Single pixel: start org(10,20); pix (0,0,color 5,last) at n → fb_we_n low only in n+4 with fb_addr=6410, fb_wdata=5; done=1 and busy=0 in n+6.
- Full sprite: start org(10,20); 225 pixels row-major, one every 3 cycles, color 3, last on (14,14) → exactly 225 write strobes; final fb_addr=(34*320)+24=10904; overflow=0; one done pulse.
- Skip/clip: org(315,0); pixels (4,0,c=7), (5,0,c=7), (0,1,c=0,last) → one write at addr 319; x=320 pixel dropped; transparent pixel not written; done still pulses.
- Overflow: start, then pix_valid every cycle for 8 cycles, last on the 8th → overflow=1 and fewer than 8 writes; the next start clears overflow.
- Reset mid-write: Reset sampled during STROBE → fb_we_n=1 and fb_ce_n=1 the next cycle, busy=0, no further writes. A following start plus single pixel writes normally.
